// File: rtl/req_ack_pkg.sv
// req_ack_pkg: shared state encoding, stat width and counter-width helper
package req_ack_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} issuer_state_t;
  localparam int STAT_W = 16;
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/req_ack_fifo.sv
// req_ack_fifo: count-based command FIFO with exact power-of-two pointer wrap
module req_ack_fifo
  import req_ack_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] head,
  output logic              full,
  output logic              empty
);
  localparam int AW = cnt_w(DEPTH);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr, cnt;
  logic do_push, do_pop;
  assign full    = cnt == (AW+1)'(DEPTH);
  assign empty   = cnt == '0;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr[AW-1:0]];
  // storage needs no reset: head is only consumed while the FIFO is non-empty
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= data_in;
  end
  // pointers and occupancy; simultaneous push and pop leaves the count unchanged
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop) cnt <= cnt + 1'b1;
      else if (do_pop && !do_push) cnt <= cnt - 1'b1;
    end
  end
endmodule

// File: rtl/req_ack_issuer.sv
// req_ack_issuer: queues commands and issues one req pulse each, retrying on ack timeout; stats ports live under REQ_ACK_ISSUER_STATS_EN
module req_ack_issuer
  import req_ack_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 4,
  parameter int TIMEOUT   = 6,
  parameter int MAX_RETRY = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              req,
  output logic [DATA_W-1:0] req_data,
  input  logic              ack,
  output logic              done_valid,
  output logic              done_err,
  output logic [DATA_W-1:0] done_data,
  output logic              busy,
  output logic [STAT_W-1:0] stat_ok,
  output logic [STAT_W-1:0] stat_err
);
  localparam int TW = cnt_w(TIMEOUT);
  localparam int RW = cnt_w(MAX_RETRY + 1);
  issuer_state_t state, state_n;
  logic [TW-1:0] tcnt, tcnt_n;
  logic [RW-1:0] rcnt, rcnt_n;
  logic err, err_n;
  logic full, empty;
  logic [DATA_W-1:0] head;
  req_ack_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .push(cmd_valid && cmd_ready),
    .pop(state == DONE),
    .data_in(cmd_data),
    .head(head),
    .full(full),
    .empty(empty)
  );
  assign cmd_ready  = !full;
  assign req        = state == ISSUE;
  assign done_valid = state == DONE;
  assign done_err   = done_valid && err;
  assign req_data   = (state != IDLE) ? head : '0;
  assign done_data  = done_valid ? head : '0;
  assign busy       = (state != IDLE) || !empty;
  // FSM and attempt counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      tcnt  <= '0;
      rcnt  <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_n;
      tcnt  <= tcnt_n;
      rcnt  <= rcnt_n;
      err   <= err_n;
    end
  end
  // next state: ack wins over a coincident timeout, ack outside WAIT is ignored
  always_comb begin
    state_n = state;
    tcnt_n  = tcnt;
    rcnt_n  = rcnt;
    err_n   = err;
    unique case (state)
      IDLE: begin
        rcnt_n  = '0;
        state_n = empty ? IDLE : ISSUE;
      end
      ISSUE: begin
        tcnt_n  = '0;
        state_n = WAIT;
      end
      WAIT: begin
        tcnt_n = tcnt + 1'b1;
        if (ack) begin
          err_n   = 1'b0;
          state_n = DONE;
        end else if (tcnt == TW'(TIMEOUT - 1)) begin
          if (rcnt == RW'(MAX_RETRY)) begin
            err_n   = 1'b1;
            state_n = DONE;
          end else begin
            rcnt_n  = rcnt + 1'b1;
            state_n = ISSUE;
          end
        end
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
`ifdef REQ_ACK_ISSUER_STATS_EN
  logic [STAT_W-1:0] ok_q, err_q;
  // saturating completion counters, cleared only by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ok_q  <= '0;
      err_q <= '0;
    end else if (done_valid) begin
      if (!done_err && ok_q != '1) ok_q <= ok_q + 1'b1;
      if (done_err && err_q != '1) err_q <= err_q + 1'b1;
    end
  end
  assign stat_ok  = ok_q;
  assign stat_err = err_q;
`else
  assign stat_ok  = '0;
  assign stat_err = '0;
`endif
endmodule

// File: tb/tb_req_ack_issuer.sv
// tb_req_ack_issuer: directed tests with a responder model and a done scoreboard
module tb_req_ack_issuer;
  import req_ack_pkg::*;
`ifdef REQ_ACK_ISSUER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cmd_valid = 1'b0;
  logic [7:0] cmd_data = '0;
  logic ack = 1'b0;
  logic cmd_ready, req, done_valid, done_err, busy;
  logic [7:0] req_data, done_data;
  logic [STAT_W-1:0] stat_ok, stat_err;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int poke_at = -1;
  int last_acc = 0;
  logic [8:0] exp_q[$];
  int plan[$];
  int req_cycles[$];
  int done_cycles[$];

  req_ack_issuer #(.DATA_W(8), .DEPTH(4), .TIMEOUT(6), .MAX_RETRY(2)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_data(cmd_data),
    .req(req),
    .req_data(req_data),
    .ack(ack),
    .done_valid(done_valid),
    .done_err(done_err),
    .done_data(done_data),
    .busy(busy),
    .stat_ok(stat_ok),
    .stat_err(stat_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // responder: each req takes the next delay from plan (default 2), -1 means never ack
  initial begin
    int ack_at;
    int d;
    ack_at = -1;
    forever begin
      @(negedge clk);
      ack = 1'b0;
      if (!rst_n) begin
        ack_at = -1;
      end else begin
        if (ack_at == cyc || poke_at == cyc) ack = 1'b1;
        if (req) begin
          d = (plan.size() > 0) ? plan.pop_front() : 2;
          ack_at = (d > 0) ? cyc + d : -1;
        end
      end
    end
  end

  // monitor: records req/done timing and scores every completion
  initial begin
    logic [8:0] e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (req) begin
          if (req_cycles.size() > 0) chk("req_gap_ge3", 32'(cyc - req_cycles[$] >= 3), 32'd1);
          if (exp_q.size() > 0) chk("req_data", 32'(req_data), 32'(exp_q[0][7:0]));
          req_cycles.push_back(cyc);
        end
        if (done_valid) begin
          done_cycles.push_back(cyc);
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL done_unexpected: got data=%0h err=%0b expected no done", done_data, done_err);
          end else begin
            e = exp_q.pop_front();
            chk("done_data", 32'(done_data), 32'(e[7:0]));
            chk("done_err", 32'(done_err), 32'(e[8]));
          end
        end
      end
    end
  end

  task automatic idle_outputs(input string tag);
    chk({tag, "_req"}, 32'(req), 32'd0);
    chk({tag, "_req_data"}, 32'(req_data), 32'd0);
    chk({tag, "_done_valid"}, 32'(done_valid), 32'd0);
    chk({tag, "_done_data"}, 32'(done_data), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
    chk({tag, "_stat_ok"}, 32'(stat_ok), 32'd0);
    chk({tag, "_stat_err"}, 32'(stat_err), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    exp_q.delete();
    plan.delete();
    req_cycles.delete();
    done_cycles.delete();
    poke_at = -1;
    rst_n = 1'b1;
  endtask

  task automatic send(input logic [7:0] d, input logic e);
    int n;
    n = 0;
    cmd_valid = 1'b1;
    cmd_data = d;
    while (!cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("send_ready", 32'(cmd_ready), 32'd1);
    last_acc = cyc;
    exp_q.push_back({e, d});
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_idle"}, 32'(busy), 32'd0);
    chk({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int min_gap;
    int acc5;
    do_reset();
    idle_outputs("reset");

    // single command, ack in the 2nd WAIT cycle: DONE is the 4th cycle counting the req cycle
    send(8'hA5, 1'b0);
    wait_idle("t1");
    chk("t1_req_count", 32'(req_cycles.size()), 32'd1);
    chk("t1_done_count", 32'(done_cycles.size()), 32'd1);
    if (req_cycles.size() == 1 && done_cycles.size() == 1)
      chk("t1_done_lat", 32'(done_cycles[0] - req_cycles[0]), 32'd3);

    // five commands with cmd_valid held: back-pressure after four
    do_reset();
    for (int i = 0; i < 4; i++) send(8'h10 + 8'(i), 1'b0);
    chk("t2_full_ready", 32'(cmd_ready), 32'd0);
    send(8'h14, 1'b0);
    acc5 = last_acc;
    wait_idle("t2");
    chk("t2_done_count", 32'(done_cycles.size()), 32'd5);
    chk("t2_req_count", 32'(req_cycles.size()), 32'd5);
    if (done_cycles.size() > 0) chk("t2_5th_after_pop", 32'(acc5), 32'(done_cycles[0] + 1));
    min_gap = 1000;
    for (int i = 1; i < req_cycles.size(); i++)
      if (req_cycles[i] - req_cycles[i-1] < min_gap) min_gap = req_cycles[i] - req_cycles[i-1];
    chk("t2_min_req_gap", 32'(min_gap), 32'd5);
    chk("t2_stat_ok", 32'(stat_ok), STATS ? 32'd5 : 32'd0);

    // responder never acks: three attempts 7 cycles apart, then error
    do_reset();
    for (int i = 0; i < 3; i++) plan.push_back(-1);
    send(8'h3C, 1'b1);
    wait_idle("t3");
    chk("t3_req_count", 32'(req_cycles.size()), 32'd3);
    if (req_cycles.size() == 3 && done_cycles.size() == 1) begin
      chk("t3_gap1", 32'(req_cycles[1] - req_cycles[0]), 32'd7);
      chk("t3_gap2", 32'(req_cycles[2] - req_cycles[1]), 32'd7);
      chk("t3_done_lat", 32'(done_cycles[0] - req_cycles[2]), 32'd7);
    end
    chk("t3_stat_ok", 32'(stat_ok), 32'd0);
    chk("t3_stat_err", 32'(stat_err), STATS ? 32'd1 : 32'd0);

    // first attempt unanswered, second acked
    do_reset();
    plan.push_back(-1);
    plan.push_back(2);
    send(8'h5A, 1'b0);
    wait_idle("t4");
    chk("t4_req_count", 32'(req_cycles.size()), 32'd2);
    if (req_cycles.size() == 2) chk("t4_gap", 32'(req_cycles[1] - req_cycles[0]), 32'd7);
    chk("t4_stat_ok", 32'(stat_ok), STATS ? 32'd1 : 32'd0);
    chk("t4_stat_err", 32'(stat_err), 32'd0);

    // spurious ack in IDLE, then ack exactly on the timeout threshold
    do_reset();
    poke_at = cyc + 2;
    repeat (6) @(negedge clk);
    chk("t5_idle_req", 32'(req_cycles.size()), 32'd0);
    chk("t5_idle_done", 32'(done_cycles.size()), 32'd0);
    chk("t5_idle_busy", 32'(busy), 32'd0);
    plan.push_back(6);
    send(8'hC3, 1'b0);
    wait_idle("t5");
    chk("t5_req_count", 32'(req_cycles.size()), 32'd1);
    if (req_cycles.size() == 1 && done_cycles.size() == 1)
      chk("t5_done_lat", 32'(done_cycles[0] - req_cycles[0]), 32'd7);

    // reset while waiting with commands queued
    do_reset();
    for (int i = 0; i < 8; i++) plan.push_back(-1);
    for (int i = 0; i < 4; i++) send(8'h70 + 8'(i), 1'b0);
    chk("t6_in_flight", 32'(req_cycles.size()), 32'd1);
    rst_n = 1'b0;
    #1;
    idle_outputs("t6_async");
    exp_q.delete();
    plan.delete();
    req_cycles.delete();
    done_cycles.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    chk("t6_no_done", 32'(done_cycles.size()), 32'd0);
    chk("t6_no_req", 32'(req_cycles.size()), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end
endmodule
